// File: rtl/rom_sram_loader.sv
// Boot-time copy engine: streams LEN ROM bytes into external SRAM at DEST_BASE,
// then optionally reads them back and reports the first mismatching offset.
module rom_sram_loader #(
   parameter int                 ROM_AW    = 14,
   parameter int                 SRAM_AW   = 19,
   parameter int                 LEN       = 16384,
   parameter logic [SRAM_AW-1:0] DEST_BASE = SRAM_AW'(19'h08000),
   parameter int                 WE_CYCLES = 2,
   parameter int                 OE_CYCLES = 2,
   parameter int                 VERIFY    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [ROM_AW-1:0]  rom_a,
   input  logic [7:0]         rom_dout,
   output logic [SRAM_AW-1:0] sram_a,
   output logic [7:0]         sram_d,
   input  logic [7:0]         sram_din,
   output logic               sram_we_n,
   output logic               sram_oe_n,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [ROM_AW-1:0]  err_addr
);

   localparam int                CNT_W    = 16;
   localparam int                SUM_W    = (ROM_AW > SRAM_AW) ? ROM_AW : SRAM_AW;
   localparam logic [CNT_W-1:0]  WE_LAST  = CNT_W'(WE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  OE_LAST  = CNT_W'(OE_CYCLES - 1);
   localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(LEN - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RADDR,
      S_RDATA,
      S_WSETUP,
      S_WPULSE,
      S_WHOLD,
      S_VADDR,
      S_VREAD,
      S_VGAP,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ROM_AW-1:0] idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        sram_d_q, sram_d_d;
   logic              we_n_q, we_n_d;
   logic              oe_n_q, oe_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [ROM_AW-1:0] err_addr_q, err_addr_d;
   logic [SUM_W-1:0]  addr_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         sram_d_q   <= '0;
         we_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         sram_d_q   <= sram_d_d;
         we_n_q     <= we_n_d;
         oe_n_q     <= oe_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_addr_q <= err_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      sram_d_d   = sram_d_q;
      error_d    = error_q;
      err_addr_d = err_addr_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               idx_d      = '0;
               error_d    = 1'b0;
               err_addr_d = '0;
               state_d    = S_RADDR;
            end
         end
         S_RADDR:  state_d = S_RDATA;
         S_RDATA: begin
            sram_d_d = rom_dout;
            state_d  = S_WSETUP;
         end
         S_WSETUP: begin
            cnt_d   = '0;
            state_d = S_WPULSE;
         end
         S_WPULSE: begin
            if (cnt_q == WE_LAST) state_d = S_WHOLD;
            else                  cnt_d   = cnt_q + 1'b1;
         end
         S_WHOLD: begin
            if (idx_q == LAST_IDX) begin
               if (VERIFY != 0) begin
                  idx_d   = '0;
                  state_d = S_VADDR;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_RADDR;
            end
         end
         S_VADDR: begin
            cnt_d   = '0;
            state_d = S_VREAD;
         end
         S_VREAD: begin
            // rom_a has been held at idx since VADDR, so rom_dout is the reference byte
            if (cnt_q == OE_LAST) begin
               if (sram_din != rom_dout) begin
                  error_d    = 1'b1;
                  err_addr_d = idx_q;
                  state_d    = S_DONE;
               end else begin
                  state_d = S_VGAP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_VGAP: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_VADDR;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Strobes and status are registered from the next state so they align with it
      we_n_d = (state_d != S_WPULSE);
      oe_n_d = !((state_d == S_VADDR) || (state_d == S_VREAD));
      busy_d = !((state_d == S_IDLE) || (state_d == S_DONE));
      done_d = (state_d == S_DONE);
   end

   assign addr_sum  = SUM_W'(DEST_BASE) + SUM_W'(idx_q);
   assign sram_a    = addr_sum[SRAM_AW-1:0];
   assign rom_a     = idx_q;
   assign sram_d    = sram_d_q;
   assign sram_we_n = we_n_q;
   assign sram_oe_n = oe_n_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign err_addr  = err_addr_q;

endmodule
